// File: rtl/instr_encode_loader_if.sv
// ---------------------------------------------------------------------------
// instr_encode_loader_if
//   Bundles the field-level request channel from the boot/test host and the
//   IMEM write port driven by instr_encode_loader.
//
//   master : host side. It drives the requests and observes the status and
//            IMEM write outputs.
//   slave  : loader side. It consumes the requests and drives the status and
//            IMEM write outputs.
//
//   Signals
//     start        session start, which rewinds the address and clears err
//     valid_in     request valid
//     ready_out    loader can accept a request
//     instr_class  0 R, 1 I-ALU, 2 LW, 3 SW, 4 BEQ, 5 JAL, 6-7 illegal
//     rd/rs1/rs2   register fields
//     funct3       R / I-ALU funct3
//     funct7b5     instruction bit 30 (sub/sra/srai)
//     imm          21-bit signed immediate (byte offset for BEQ/JAL)
//     last         final request of the session
//     imem_we      one-cycle IMEM write strobe
//     imem_addr    IMEM byte address
//     imem_wdata   encoded RV32I word
//     busy         session active
//     done         one-cycle pulse after the last word
//     err          sticky error flag
// ---------------------------------------------------------------------------
interface instr_encode_loader_if #(
  parameter int ADDR_W = 32
);
  logic              start;
  logic              valid_in;
  logic              ready_out;
  logic [2:0]        instr_class;
  logic [4:0]        rd;
  logic [4:0]        rs1;
  logic [4:0]        rs2;
  logic [2:0]        funct3;
  logic              funct7b5;
  logic [20:0]       imm;
  logic              last;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              busy;
  logic              done;
  logic              err;

  modport master (
    output start, valid_in, instr_class, rd, rs1, rs2, funct3, funct7b5,
           imm, last,
    input  ready_out, imem_we, imem_addr, imem_wdata, busy, done, err
  );

  modport slave (
    input  start, valid_in, instr_class, rd, rs1, rs2, funct3, funct7b5,
           imm, last,
    output ready_out, imem_we, imem_addr, imem_wdata, busy, done, err
  );
endinterface

// File: rtl/instr_encode_loader.sv
// ---------------------------------------------------------------------------
// instr_encode_loader
//   Encodes field-level instruction requests into 32-bit RV32I words and
//   writes them sequentially into instruction memory. One word is written
//   per accepted request. The write strobe, address and data are registered
//   and appear one cycle after the handshake.
//
//   Parameters
//     ADDR_W     width of the IMEM byte address
//     BASE_ADDR  byte address of the first word written in a session
//     DEPTH      maximum number of words written per session
//
//   Ports
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset
//     bus    instr_encode_loader_if.slave (requests in, IMEM write and status out)
//
//   Build option
//     IMM_RANGE_CHECK_EN  When this macro is defined, each immediate must fit
//                         its format: I/S signed 12 bits, B signed 13 bits and
//                         even, J even. A violating request writes nothing and
//                         sets err. When the macro is undefined, out-of-range
//                         bits are dropped and bit 0 is ignored for B/J.
// ---------------------------------------------------------------------------
module instr_encode_loader #(
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int                DEPTH     = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  instr_encode_loader_if.slave   bus
);

  localparam int             CNT_W   = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  localparam logic [2:0] CLS_R    = 3'd0;
  localparam logic [2:0] CLS_IALU = 3'd1;
  localparam logic [2:0] CLS_LW   = 3'd2;
  localparam logic [2:0] CLS_SW   = 3'd3;
  localparam logic [2:0] CLS_BEQ  = 3'd4;
  localparam logic [2:0] CLS_JAL  = 3'd5;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  count_q;
  logic [ADDR_W-1:0] addr_q;
  logic              we_q;
  logic [ADDR_W-1:0] waddr_q;
  logic [31:0]       wdata_q;
  logic              err_q;

  logic        has_room;
  logic        ready;
  logic        handshake;
  logic        class_legal;
  logic        range_ok;
  logic        do_write;
  logic        overflow_req;
  logic        set_err;
  logic [31:0] enc_word;

  assign has_room = (count_q < DEPTH_C);
  assign ready    = (state_q == ST_LOAD) && has_room;

  // A start in the same cycle takes priority and discards the request.
  assign handshake    = bus.valid_in && ready && !bus.start;
  assign class_legal  = (bus.instr_class <= CLS_JAL);
  assign do_write     = handshake && class_legal && range_ok;
  assign overflow_req = (state_q == ST_LOAD) && bus.valid_in && !has_room && !bus.start;
  assign set_err      = (handshake && !(class_legal && range_ok)) || overflow_req;

`ifdef IMM_RANGE_CHECK_EN
  // The upper immediate bits must be copies of the format's sign bit.
  // Branch and jump offsets must also be even.
  always_comb begin
    range_ok = 1'b1;
    case (bus.instr_class)
      CLS_IALU, CLS_LW, CLS_SW: range_ok = (bus.imm[20:11] == {10{bus.imm[11]}});
      CLS_BEQ:                  range_ok = (bus.imm[20:12] == {9{bus.imm[12]}}) && !bus.imm[0];
      CLS_JAL:                  range_ok = !bus.imm[0];
      default:                  range_ok = 1'b1;
    endcase
  end
`else
  assign range_ok = 1'b1;
`endif

  // Field-to-word encoder. Register fields that a format does not use are
  // left at zero. For shift-right-immediate, bit 30 comes from funct7b5 so
  // that srli and srai can be told apart.
  always_comb begin
    enc_word = 32'h0;
    case (bus.instr_class)
      CLS_R: begin
        enc_word = {1'b0, bus.funct7b5, 5'b0, bus.rs2, bus.rs1, bus.funct3, bus.rd, OP_R};
      end
      CLS_IALU: begin
        enc_word = {bus.imm[11:0], bus.rs1, bus.funct3, bus.rd, OP_I};
        if (bus.funct3 == 3'b101) begin
          enc_word[30] = bus.funct7b5;
        end
      end
      CLS_LW: begin
        enc_word = {bus.imm[11:0], bus.rs1, 3'b010, bus.rd, OP_LW};
      end
      CLS_SW: begin
        enc_word = {bus.imm[11:5], bus.rs2, bus.rs1, 3'b010, bus.imm[4:0], OP_SW};
      end
      CLS_BEQ: begin
        enc_word = {bus.imm[12], bus.imm[10:5], bus.rs2, bus.rs1, 3'b000,
                    bus.imm[4:1], bus.imm[11], OP_BEQ};
      end
      CLS_JAL: begin
        enc_word = {bus.imm[20], bus.imm[10:1], bus.imm[11], bus.imm[19:12],
                    bus.rd, OP_JAL};
      end
      default: enc_word = 32'h0;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Session sequencing. Start restarts from any state. An accepted last
  // request ends the session even when it wrote nothing. A capacity stall
  // holds in LOAD until the next start.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        if (bus.start)                  state_d = ST_LOAD;
        else if (handshake && bus.last) state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = bus.start ? ST_LOAD : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Write port and session counters. A write latched in the previous cycle
  // still completes when a start arrives, because we_q is already set. Start
  // clears err even if an error would be raised in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      addr_q  <= BASE_ADDR;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      we_q <= do_write;
      if (do_write) begin
        waddr_q <= addr_q;
        wdata_q <= enc_word;
      end
      if (bus.start) begin
        addr_q  <= BASE_ADDR;
        count_q <= '0;
      end else if (do_write) begin
        addr_q  <= addr_q + ADDR_W'(4);
        count_q <= count_q + CNT_W'(1);
      end
      if (bus.start) begin
        err_q <= 1'b0;
      end else if (set_err) begin
        err_q <= 1'b1;
      end
    end
  end

  assign bus.ready_out  = ready;
  assign bus.imem_we    = we_q;
  assign bus.imem_addr  = waddr_q;
  assign bus.imem_wdata = wdata_q;
  assign bus.busy       = (state_q == ST_LOAD);
  assign bus.done       = (state_q == ST_DONE);
  assign bus.err        = err_q;

endmodule

// File: tb/tb_instr_encode_loader.sv
// ---------------------------------------------------------------------------
// tb_instr_encode_loader
//   Drives instr_encode_loader through directed and random request steps.
//   Each step is checked against a behavioural model of a loader session.
// ---------------------------------------------------------------------------
module tb_instr_encode_loader;

  localparam int          ADDR_W = 32;
  localparam int          DEPTH  = 8;
  localparam logic [31:0] BASE   = 32'h0;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  instr_encode_loader_if #(.ADDR_W(ADDR_W)) bus ();

  instr_encode_loader #(
    .ADDR_W   (ADDR_W),
    .BASE_ADDR(BASE),
    .DEPTH    (DEPTH)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Session model state.
  bit          m_active;
  bit          m_done;
  bit          m_err;
  int          m_count;
  logic [31:0] m_addr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference encoder, built by shifting and masking each field into place.
  function automatic logic [31:0] ref_encode(int cls, int rd, int rs1, int rs2,
                                             int f3, int f7, int imm);
    logic [31:0] u;
    logic [31:0] r, d, s1, s2, f;
    u  = imm;
    d  = rd;
    s1 = rs1;
    s2 = rs2;
    f  = f3;
    r  = 32'h0;
    case (cls)
      0: r = 32'h33 | (d << 7) | (f << 12) | (s1 << 15) | (s2 << 20) | ((f7 != 0) ? 32'h4000_0000 : 32'h0);
      1: begin
        r = 32'h13 | (d << 7) | (f << 12) | (s1 << 15) | ((u & 32'hFFF) << 20);
        if (f3 == 5) r = (r & ~32'h4000_0000) | ((f7 != 0) ? 32'h4000_0000 : 32'h0);
      end
      2: r = 32'h03 | (d << 7) | (32'd2 << 12) | (s1 << 15) | ((u & 32'hFFF) << 20);
      3: r = 32'h23 | ((u & 32'h1F) << 7) | (32'd2 << 12) | (s1 << 15) | (s2 << 20)
             | (((u >> 5) & 32'h7F) << 25);
      4: r = 32'h63 | (((u >> 11) & 32'h1) << 7) | (((u >> 1) & 32'hF) << 8) | (s1 << 15)
             | (s2 << 20) | (((u >> 5) & 32'h3F) << 25) | (((u >> 12) & 32'h1) << 31);
      5: r = 32'h6F | (d << 7) | (((u >> 12) & 32'hFF) << 12) | (((u >> 11) & 32'h1) << 20)
             | (((u >> 1) & 32'h3FF) << 21) | (((u >> 20) & 32'h1) << 31);
      default: r = 32'h0;
    endcase
    return r;
  endfunction

  function automatic bit ref_legal(int cls, int imm);
    bit ok;
    ok = (cls >= 0) && (cls <= 5);
`ifdef IMM_RANGE_CHECK_EN
    if (cls >= 1 && cls <= 3) ok = ok && (imm >= -2048) && (imm <= 2047);
    if (cls == 4) ok = ok && (imm >= -4096) && (imm <= 4095) && ((imm % 2) == 0);
    if (cls == 5) ok = ok && ((imm % 2) == 0);
`endif
    return ok;
  endfunction

  function automatic int sext21(logic [20:0] v);
    return int'($signed(v));
  endfunction

  task automatic model_reset();
    m_active = 1'b0;
    m_done   = 1'b0;
    m_err    = 1'b0;
    m_count  = 0;
    m_addr   = BASE;
  endtask

  // Runs one clock step. Inputs are driven 1 time unit after a rising edge,
  // and outputs are checked 1 time unit after the next rising edge.
  task automatic applyStimulus(input bit st, input bit vld, input int cls, input int rd,
                               input int rs1, input int rs2, input int f3, input int f7,
                               input int imm, input bit lst);
    bit          exp_we;
    logic [31:0] exp_addr, exp_data;
    int          imm21;
    logic [31:0] imm_bits;
    imm_bits = imm;
    imm21    = sext21(imm_bits[20:0]);
    check("ready_out", {31'b0, bus.ready_out}, {31'b0, m_active && (m_count < DEPTH)});
    bus.start       = st;
    bus.valid_in    = vld;
    bus.instr_class = cls[2:0];
    bus.rd          = rd[4:0];
    bus.rs1         = rs1[4:0];
    bus.rs2         = rs2[4:0];
    bus.funct3      = f3[2:0];
    bus.funct7b5    = f7[0];
    bus.imm         = imm_bits[20:0];
    bus.last        = lst;
    @(posedge clk);
    #1;
    exp_we   = 1'b0;
    exp_addr = 32'h0;
    exp_data = 32'h0;
    if (st) begin
      m_active = 1'b1;
      m_count  = 0;
      m_addr   = BASE;
      m_err    = 1'b0;
      m_done   = 1'b0;
    end else if (m_active) begin
      m_done = 1'b0;
      if (vld) begin
        if (m_count < DEPTH) begin
          if (ref_legal(cls, imm21)) begin
            exp_we   = 1'b1;
            exp_addr = m_addr;
            exp_data = ref_encode(cls, rd & 31, rs1 & 31, rs2 & 31, f3 & 7, f7 & 1, imm21);
            m_addr   = m_addr + 32'd4;
            m_count++;
          end else begin
            m_err = 1'b1;
          end
          if (lst) begin
            m_active = 1'b0;
            m_done   = 1'b1;
          end
        end else begin
          m_err = 1'b1;
        end
      end
    end else begin
      m_done = 1'b0;
    end
    checkOutput(exp_we, exp_addr, exp_data);
    bus.start    = 1'b0;
    bus.valid_in = 1'b0;
    bus.last     = 1'b0;
  endtask

  task automatic checkOutput(input bit exp_we, input logic [31:0] exp_addr,
                             input logic [31:0] exp_data);
    check("imem_we", {31'b0, bus.imem_we}, {31'b0, exp_we});
    check("busy",    {31'b0, bus.busy},    {31'b0, m_active});
    check("done",    {31'b0, bus.done},    {31'b0, m_done});
    check("err",     {31'b0, bus.err},     {31'b0, m_err});
    if (exp_we) begin
      check("imem_addr",  bus.imem_addr,  exp_addr);
      check("imem_wdata", bus.imem_wdata, exp_data);
    end
  endtask

  task automatic idle_step();
    applyStimulus(1'b0, 1'b0, 0, 0, 0, 0, 0, 0, 0, 1'b0);
  endtask

  task automatic start_step();
    applyStimulus(1'b1, 1'b0, 0, 0, 0, 0, 0, 0, 0, 1'b0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_we"},    {31'b0, bus.imem_we},   32'h0);
    check({tag, "_addr"},  bus.imem_addr,          32'h0);
    check({tag, "_wdata"}, bus.imem_wdata,         32'h0);
    check({tag, "_busy"},  {31'b0, bus.busy},      32'h0);
    check({tag, "_done"},  {31'b0, bus.done},      32'h0);
    check({tag, "_err"},   {31'b0, bus.err},       32'h0);
    check({tag, "_ready"}, {31'b0, bus.ready_out}, 32'h0);
  endtask

  initial begin
    int cls, imm;
    logic [31:0] r;
    bus.start = 1'b0; bus.valid_in = 1'b0; bus.instr_class = '0;
    bus.rd = '0; bus.rs1 = '0; bus.rs2 = '0; bus.funct3 = '0;
    bus.funct7b5 = 1'b0; bus.imm = '0; bus.last = 1'b0;
    model_reset();

    // Reset state.
    #12;
    check_all_zero("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single addi x1, x0, 5.
    start_step();
    applyStimulus(0, 1, 1, 1, 0, 0, 0, 0, 5, 0);
    check("addi_word", bus.imem_wdata, 32'h0050_0093);
    check("addi_addr", bus.imem_addr,  32'h0);

    // New session: add, sub, sw, beq, jal back-to-back.
    start_step();
    applyStimulus(0, 1, 0, 3, 1, 2, 0, 0, 0, 0);
    check("add_word", bus.imem_wdata, 32'h0020_81B3);
    applyStimulus(0, 1, 0, 3, 1, 2, 0, 1, 0, 0);
    check("sub_word", bus.imem_wdata, 32'h4020_81B3);
    check("sub_addr", bus.imem_addr,  32'h4);
    applyStimulus(0, 1, 3, 0, 0, 2, 0, 0, 8, 0);
    check("sw_word", bus.imem_wdata, 32'h0020_2423);
    applyStimulus(0, 1, 4, 0, 1, 2, 0, 0, -4, 0);
    check("beq_word", bus.imem_wdata, 32'hFE20_8EE3);
    applyStimulus(0, 1, 5, 1, 0, 0, 0, 0, 8, 1);
    check("jal_word", bus.imem_wdata, 32'h0080_00EF);
    check("jal_done", {31'b0, bus.done}, 32'h1);
    idle_step();
    check("after_done_busy", {31'b0, bus.busy}, 32'h0);

    // Valid outside a session is ignored.
    applyStimulus(0, 1, 1, 1, 0, 0, 0, 0, 7, 0);

    // Illegal class, then start clears err.
    start_step();
    applyStimulus(0, 1, 6, 1, 2, 3, 0, 0, 0, 0);
    check("illegal_err", {31'b0, bus.err}, 32'h1);
    start_step();

    // Out-of-range I immediate (rejected only when the range check is built in).
    applyStimulus(0, 1, 1, 1, 0, 0, 0, 0, 2048, 0);

    // Fill to capacity, then overflow.
    start_step();
    for (int i = 0; i < DEPTH; i++) applyStimulus(0, 1, 1, i, i, 0, 0, 0, i, 0);
    applyStimulus(0, 1, 1, 1, 1, 0, 0, 0, 1, 0);
    check("overflow_err", {31'b0, bus.err}, 32'h1);
    // Start with a request held: start wins and clears err.
    applyStimulus(1, 1, 1, 1, 1, 0, 0, 0, 1, 0);

    // Illegal class on last still ends the session.
    applyStimulus(0, 1, 7, 0, 0, 0, 0, 0, 0, 1);
    idle_step();

    // Random sessions.
    for (int n = 0; n < 300; n++) begin
      r = $urandom;
      cls = (r[3:0] < 4'd13) ? int'($urandom_range(0, 5)) : int'($urandom_range(6, 7));
      imm = r[4] ? (int'($urandom_range(0, 8191)) - 4096) : sext21(21'($urandom));
      applyStimulus(r[31:26] == 6'd0 || (!m_active && r[25:23] == 3'd0),
                    r[7:5] != 3'd0, cls, int'($urandom_range(0, 31)),
                    int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
                    int'($urandom_range(0, 7)), int'(r[8]), imm, r[22:19] == 4'd0);
    end

    // Reset asserted while a write is in flight.
    start_step();
    applyStimulus(0, 1, 0, 5, 6, 7, 0, 0, 0, 0);
    rst_n = 1'b0;
    #1;
    check_all_zero("midreset");
    model_reset();
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    idle_step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
